serial_pattern_tx: RTL and testbench

- Serial bit-pattern transmitter.
- Accepts a parallel pattern word with a bit length and a repeat count, then drives it MSB-first onto a 1-bit serial line `x`, one bit per clock.
- Bit-serial stimulus source for the team's serial sequence detectors (e.g. sequence_detector_110_moore, ports rst/clk/x/y); also usable as a generic PISO line driver.

---
 rtl/serial_tx_pkg.sv | 21 ++
 rtl/piso_shift_reg.sv | 39 +++
 rtl/serial_pattern_tx.sv | 176 +++++++++++++++++
 tb/tb_serial_pattern_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared state type and width helpers for the serial pattern transmitter
package serial_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_DONE
  } tx_state_e;

  // Width of a counter that must hold every value 0..w inclusive (the LEN_W rule).
  function automatic int len_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Same as len_width but never narrower than one bit, for counters whose range may be empty.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-load, shift-left register presenting its MSB as the next line bit
module piso_shift_reg
  import serial_tx_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         head_o
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;
  logic [W-1:0] word;

  // The word about to be consumed: fresh data on load, else the held remainder; its MSB goes out
  // now and the rest is kept shifted up for the following cycles.
  always_comb begin
    word   = load_i ? data_i : sr_q;
    head_o = word[W-1];
    sr_d   = sr_q;
    if (load_i || shift_i) begin
      sr_d = word << 1;
    end
  end

  // Shift register storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - MSB-first serial pattern transmitter with repeat count and inter-repeat gap
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int W     = 8,
  parameter int GAP   = 2,
  parameter int RPT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    ready,
  input  logic [W-1:0]            pattern,
  input  logic [len_width(W)-1:0] len,
  input  logic [RPT_W-1:0]        reps,
  output logic                    x,
  output logic                    x_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int LEN_W = len_width(W);
  localparam int GAP_W = cnt_width(GAP);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(W);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  tx_state_e        state_q;
  logic [W-1:0]     pat_q;      // captured pattern, left-justified so its first bit sits at W-1
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_cnt_q;  // bits still to send after the one currently on the line
  logic [RPT_W-1:0] rep_cnt_q;  // repetitions still owed after the current one
  logic [GAP_W-1:0] gap_cnt_q;  // idle cycles still owed after the current one
  logic             x_q;
  logic             x_valid_q;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic             last_bit;
  logic [LEN_W-1:0] len_clamped;
  logic [W-1:0]     pat_aligned;
  logic             sr_load;
  logic             sr_shift;
  logic [W-1:0]     sr_data;
  logic             sr_head;

  assign ready    = (state_q == S_IDLE);
  assign accept   = start && ready;
  assign last_bit = (bit_cnt_q == '0);

  assign x        = x_q;
  assign x_valid  = x_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Clamp the requested length and left-justify the window so bit len-1 lands on W-1.
  always_comb begin
    len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
    pat_aligned = pattern << (LEN_MAX - len_clamped);
  end

  // Decide when the shift register takes a fresh window and when it advances one bit.
  always_comb begin
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_data  = pat_q;
    case (state_q)
      S_IDLE: begin
        sr_data = pat_aligned;
        sr_load = accept && (len_clamped != '0);
      end
      S_SHIFT: begin
        if (!last_bit) begin
          sr_shift = 1'b1;
        end else if ((rep_cnt_q != '0) && (GAP == 0)) begin
          sr_load = 1'b1;
        end
      end
      S_GAP: begin
        sr_load = (gap_cnt_q == '0);
      end
      default: begin
      end
    endcase
  end

  piso_shift_reg #(
    .W(W)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .data_i  (sr_data),
    .head_o  (sr_head)
  );

  // Transmit FSM: counters plus registered line outputs describing the coming cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (accept) begin
            pat_q     <= pat_aligned;
            len_q     <= len_clamped;
            rep_cnt_q <= reps;
            busy_q    <= 1'b1;
            if (len_clamped == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_SHIFT;
              x_q       <= sr_head;
              x_valid_q <= 1'b1;
              bit_cnt_q <= len_clamped - LEN_W'(1);
            end
          end
        end
        S_SHIFT: begin
          if (!last_bit) begin
            x_q       <= sr_head;
            x_valid_q <= 1'b1;
            bit_cnt_q <= bit_cnt_q - LEN_W'(1);
          end else if (rep_cnt_q != '0) begin
            rep_cnt_q <= rep_cnt_q - RPT_W'(1);
            if (GAP > 0) begin
              state_q   <= S_GAP;
              gap_cnt_q <= GAP_LAST;
            end else begin
              // No gap: the next repetition's first bit follows without a bubble.
              x_q       <= sr_head;
              x_valid_q <= 1'b1;
              bit_cnt_q <= len_q - LEN_W'(1);
            end
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt_q != '0) begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end else begin
            state_q   <= S_SHIFT;
            x_q       <= sr_head;
            x_valid_q <= 1'b1;
            bit_cnt_q <= len_q - LEN_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - self-checking bench for serial_pattern_tx
module tb_serial_pattern_tx;
  import serial_tx_pkg::*;

  localparam int W     = 8;
  localparam int GAP   = 2;
  localparam int RPT_W = 4;
  localparam int LEN_W = len_width(W);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start, ready, x, x_valid, busy, done;
  logic [W-1:0]     pattern;
  logic [LEN_W-1:0] len;
  logic [RPT_W-1:0] reps;

  logic             start0, ready0, x0, xv0, busy0, done0;
  logic [W-1:0]     pattern0;
  logic [LEN_W-1:0] len0;
  logic [RPT_W-1:0] reps0;

  serial_pattern_tx #(.W(W), .GAP(GAP), .RPT_W(RPT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .pattern(pattern), .len(len),
    .reps(reps), .x(x), .x_valid(x_valid), .busy(busy), .done(done)
  );

  serial_pattern_tx #(.W(W), .GAP(0), .RPT_W(RPT_W)) dut_g0 (
    .clk(clk), .rst(rst), .start(start0), .ready(ready0), .pattern(pattern0), .len(len0),
    .reps(reps0), .x(x0), .x_valid(xv0), .busy(busy0), .done(done0)
  );

  typedef struct packed {
    logic xv;
    logic x;
    logic done;
    logic busy;
    logic ready;
  } obs_t;

  typedef struct {
    logic [W-1:0] pat;
    int           l;
    int           r;
    logic [63:0]  stream;
    int           n;
    int           lat;
    string        name;
  } vec_t;

  obs_t        sb[$];
  vec_t        vecs[8];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic [63:0] cap_stream = '0;
  int          cap_n = 0;
  int          done_lat = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent model: cycle-by-cycle expected {x_valid,x,done,busy,ready} for one frame.
  task automatic push_frame(input logic [W-1:0] p, input int l, input int r);
    int n;
    n = (l > W) ? W : l;
    if (n > 0) begin
      for (int rr = 0; rr <= r; rr++) begin
        for (int i = n - 1; i >= 0; i--) sb.push_back('{1'b1, p[i], 1'b0, 1'b1, 1'b0});
        if (rr < r) for (int g = 0; g < GAP; g++) sb.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
      end
    end
    sb.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    sb.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic send(input logic [W-1:0] p, input int l, input int r);
    pattern = p;
    len     = LEN_W'(l);
    reps    = RPT_W'(r);
    start   = 1'b1;
    check("ready_before_start", 64'(ready), 64'd1);
    @(posedge clk);
    #1;
    start      = 1'b0;
    acc_cyc    = cyc;
    cap_stream = '0;
    cap_n      = 0;
    done_lat   = -1;
    push_frame(p, l, r);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sb.size() > 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop one expected entry per cycle while a frame is outstanding.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {x_valid, x, done, busy, ready};
        check("trace", 64'(a), 64'(e));
        if (x_valid) begin
          cap_stream = {cap_stream[62:0], x};
          cap_n++;
        end
        if (done) done_lat = cyc - acc_cyc + 1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    int done_at;

    vecs[0] = '{8'h06, 3,  0, 64'b110,      3,  4,  "single"};
    vecs[1] = '{8'h06, 3,  1, 64'b110110,   6,  9,  "rep_gap"};
    vecs[2] = '{8'hFF, 0,  0, 64'd0,        0,  1,  "len0"};
    vecs[3] = '{8'hA5, 15, 0, 64'hA5,       8,  9,  "len15"};
    vecs[4] = '{8'hA5, 8,  2, 64'hA5A5A5,   24, 29, "rep3"};
    vecs[5] = '{8'hF0, 5,  0, 64'b10000,    5,  6,  "win5"};
    vecs[6] = '{8'h01, 1,  15, 64'hFFFF,    16, 47, "rep15_gap"};
    vecs[7] = '{8'h80, 8,  0, 64'h80,       8,  9,  "full"};

    rst = 1'b1; start = 1'b0; pattern = '0; len = '0; reps = '0;
    start0 = 1'b0; pattern0 = '0; len0 = '0; reps0 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", 64'({x_valid, x, done, busy, ready}), 64'b00001);
    check("reset_state_g0", 64'({xv0, x0, done0, busy0, ready0}), 64'b00001);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].pat, vecs[i].l, vecs[i].r);
      drain(200);
      check({vecs[i].name, "_stream"}, cap_stream, vecs[i].stream);
      check({vecs[i].name, "_nbits"}, 64'(cap_n), 64'(vecs[i].n));
      check({vecs[i].name, "_latency"}, 64'(done_lat), 64'(vecs[i].lat));
    end

    // Start held high: frames separated by DONE + one IDLE cycle; mid-frame pattern change ignored.
    pattern = 8'h02; len = LEN_W'(2); reps = '0; start = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc; cap_stream = '0; cap_n = 0; done_lat = -1;
    pattern = 8'h01;
    push_frame(8'h02, 2, 0);
    push_frame(8'h01, 2, 0);
    repeat (4) @(posedge clk);
    #1 start = 1'b0;
    drain(100);
    check("b2b_stream", cap_stream, 64'b1001);
    check("b2b_nbits", 64'(cap_n), 64'd4);
    check("b2b_latency", 64'(done_lat), 64'd7);

    // Reset in the middle of a repeated frame aborts without a done pulse.
    pattern = 8'hFF; len = LEN_W'(8); reps = RPT_W'(3); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_midframe", 64'({x_valid, x, done, busy, ready}), 64'b00001);
    send(8'h06, 3, 0);
    drain(100);
    check("after_reset_stream", cap_stream, 64'b110);
    check("after_reset_latency", 64'(done_lat), 64'd4);

    // GAP=0 instance: 16 back-to-back bits with reps at its maximum.
    pattern0 = 8'h01; len0 = LEN_W'(1); reps0 = 4'hF; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    run = 0;
    done_at = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (xv0 && x0 && (c == run + 1)) run++;
      if (done0 && done_at < 0) done_at = c;
    end
    check("g0_consecutive_bits", 64'(run), 64'd16);
    check("g0_done_cycle", 64'(done_at), 64'd17);
    check("g0_ready_back", 64'(ready0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
